// File: rtl/pipe_stage_reg_if.sv
// Pipeline slot bundle: valid, instruction, pc, delay-slot flag, exception code, payload.
interface pipe_stage_reg_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned EXC_W  = 5
);
   logic              valid;
   logic [31:0]       instr;
   logic [31:0]       pc;
   logic              bd;
   logic [EXC_W-1:0]  exc;
   logic [DATA_W-1:0] data;

   modport master (output valid, instr, pc, bd, exc, data);
   modport slave  (input  valid, instr, pc, bd, exc, data);
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall/flush/exception-entry control.
// Optional PIPE_STAGE_PERF_EN adds saturating stall/flush event counters.
module pipe_stage_reg #(
   parameter int unsigned DATA_W        = 32,
   parameter int unsigned EXC_W         = 5,
   parameter logic [31:0] PC_RESET      = 32'h0000_3000,
   parameter logic [31:0] PC_EXC        = 32'h0000_4180,
   parameter bit          FLUSH_KEEP_PC = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req,
   input  logic             stall,
   input  logic             flush,
   input  logic [EXC_W-1:0] loc_exc,
   pipe_stage_reg_if.slave  up,
   pipe_stage_reg_if.master dn,
   output logic [15:0]      out_imm16,
   output logic [25:0]      out_imm26
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [31:0]      stall_cnt,
   output logic [31:0]      flush_cnt
`endif
);

   typedef enum logic [1:0] {ACT_LOAD, ACT_FLUSH, ACT_STALL, ACT_REQ} act_t;

   act_t              act;
   logic              valid_q;
   logic [31:0]       instr_q;
   logic [31:0]       pc_q;
   logic              bd_q;
   logic [EXC_W-1:0]  exc_q;
   logic [DATA_W-1:0] data_q;
   logic [EXC_W-1:0]  merged_exc;

   always_comb begin
      act = ACT_LOAD;
      if (req)        act = ACT_REQ;
      else if (stall) act = ACT_STALL;
      else if (flush) act = ACT_FLUSH;
   end

   // Older exception carried from upstream wins over one raised locally.
   always_comb begin
      merged_exc = '0;
      if (up.valid) merged_exc = (up.exc != '0) ? up.exc : loc_exc;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         instr_q <= '0;
         pc_q    <= PC_RESET;
         bd_q    <= 1'b0;
         exc_q   <= '0;
         data_q  <= '0;
      end else begin
         case (act)
            ACT_REQ: begin
               valid_q <= 1'b0;
               instr_q <= '0;
               pc_q    <= PC_EXC;
               bd_q    <= 1'b0;
               exc_q   <= '0;
               data_q  <= '0;
            end
            ACT_STALL: ;
            ACT_FLUSH: begin
               valid_q <= 1'b0;
               instr_q <= '0;
               if (FLUSH_KEEP_PC) pc_q <= up.pc;
               bd_q    <= 1'b0;
               exc_q   <= '0;
               data_q  <= '0;
            end
            default: begin
               valid_q <= up.valid;
               instr_q <= up.valid ? up.instr : '0;
               pc_q    <= up.pc;
               bd_q    <= up.bd;
               exc_q   <= merged_exc;
               data_q  <= up.data;
            end
         endcase
      end
   end

   assign dn.valid  = valid_q;
   assign dn.instr  = instr_q;
   assign dn.pc     = pc_q;
   assign dn.bd     = bd_q;
   assign dn.exc    = exc_q;
   assign dn.data   = data_q;
   assign out_imm16 = instr_q[15:0];
   assign out_imm26 = instr_q[25:0];

`ifdef PIPE_STAGE_PERF_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (act == ACT_STALL && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
         if (act == ACT_FLUSH && flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: two instances differing only in flush-PC policy.
module tb_pipe_stage_reg;

   logic       clk = 1'b0;
   logic       reset;
   logic       req, stall, flush;
   logic [4:0] loc_exc;
   logic [15:0] imm16_0, imm16_1;
   logic [25:0] imm26_0, imm26_1;
   int unsigned checks = 0;
   int unsigned errors = 0;
`ifdef PIPE_STAGE_PERF_EN
   logic [31:0] stall_cnt0, flush_cnt0, stall_cnt1, flush_cnt1;
`endif

   always #5 clk = ~clk;

   pipe_stage_reg_if up_if ();
   pipe_stage_reg_if dn0 ();
   pipe_stage_reg_if dn1 ();

   pipe_stage_reg #(.FLUSH_KEEP_PC(1'b1)) u_keep (
      .clk(clk), .reset(reset), .req(req), .stall(stall), .flush(flush),
      .loc_exc(loc_exc), .up(up_if), .dn(dn0),
      .out_imm16(imm16_0), .out_imm26(imm26_0)
`ifdef PIPE_STAGE_PERF_EN
      , .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
`endif
   );

   pipe_stage_reg #(.FLUSH_KEEP_PC(1'b0)) u_hold (
      .clk(clk), .reset(reset), .req(req), .stall(stall), .flush(flush),
      .loc_exc(loc_exc), .up(up_if), .dn(dn1),
      .out_imm16(imm16_1), .out_imm26(imm26_1)
`ifdef PIPE_STAGE_PERF_EN
      , .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic bd, input logic [4:0] ex, input logic [4:0] lex,
                        input logic [31:0] d);
      up_if.valid = v;
      up_if.instr = ins;
      up_if.pc    = pc;
      up_if.bd    = bd;
      up_if.exc   = ex;
      loc_exc     = lex;
      up_if.data  = d;
   endtask

   initial begin
      reset = 1'b0; req = 1'b0; stall = 1'b0; flush = 1'b0;
      drive(1'b0, '0, '0, 1'b0, '0, '0, '0);
      tick(); tick();
      reset = 1'b1;

      // load garbage, then assert reset mid-cycle
      drive(1'b1, 32'h1111_2222, 32'h0000_2000, 1'b1, 5'd3, 5'd0, 32'hAAAA_5555);
      tick();
      chk("pre_rst_instr", dn0.instr, 32'h1111_2222);
      #2 reset = 1'b0;
      #1;
      chk("rst_pc",    dn0.pc,    32'h0000_3000);
      chk("rst_instr", dn0.instr, 32'h0);
      chk("rst_valid", {31'd0, dn0.valid}, 32'd0);
      chk("rst_exc",   {27'd0, dn0.exc},   32'd0);
      chk("rst_bd",    {31'd0, dn0.bd},    32'd0);
      chk("rst_data",  dn0.data,  32'h0);
`ifdef PIPE_STAGE_PERF_EN
      chk("rst_scnt", stall_cnt0, 32'd0);
`endif
      @(negedge clk);
      reset = 1'b1;

      drive(1'b1, 32'h3C01_1234, 32'h0000_3004, 1'b0, 5'd0, 5'd0, 32'hDEAD_BEEF);
      tick();
      chk("ld_instr", dn0.instr, 32'h3C01_1234);
      chk("ld_imm16", {16'd0, imm16_0}, 32'h0000_1234);
      chk("ld_imm26", {6'd0, imm26_0}, 32'h0001_1234);
      chk("ld_pc",    dn0.pc,    32'h0000_3004);
      chk("ld_valid", {31'd0, dn0.valid}, 32'd1);
      chk("ld_data",  dn0.data,  32'hDEAD_BEEF);

      // stall 3 cycles with changing inputs
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h0BAD_0000 + i, 32'h0000_5000 + 4 * i, 1'b1, 5'd7, 5'd9, 32'h1234_0000 + i);
         tick();
         chk("stl_instr", dn0.instr, 32'h3C01_1234);
         chk("stl_pc",    dn0.pc,    32'h0000_3004);
      end
      chk("stl_bd",   {31'd0, dn0.bd},  32'd0);
      chk("stl_exc",  {27'd0, dn0.exc}, 32'd0);
      chk("stl_data", dn0.data, 32'hDEAD_BEEF);
`ifdef PIPE_STAGE_PERF_EN
      chk("stl_cnt", stall_cnt0, 32'd3);
`endif

      // req overrides stall
      req = 1'b1;
      tick();
      chk("req_pc",    dn0.pc,    32'h0000_4180);
      chk("req_instr", dn0.instr, 32'h0);
      chk("req_valid", {31'd0, dn0.valid}, 32'd0);
      chk("req_exc",   {27'd0, dn0.exc},   32'd0);
      chk("req_data",  dn0.data,  32'h0);
`ifdef PIPE_STAGE_PERF_EN
      chk("req_scnt", stall_cnt0, 32'd3);
`endif
      req = 1'b0; stall = 1'b0;

      drive(1'b1, 32'h2000_0001, 32'h0000_3008, 1'b1, 5'd0, 5'd0, 32'h0000_00AA);
      tick();
      chk("ld2_pc_hold", dn1.pc, 32'h0000_3008);

      // flush: keep-pc vs hold-pc policy
      flush = 1'b1;
      drive(1'b1, 32'h2000_0002, 32'h0000_3010, 1'b1, 5'd2, 5'd2, 32'h0000_00BB);
      tick();
      chk("fl_instr",   dn0.instr, 32'h0);
      chk("fl_valid",   {31'd0, dn0.valid}, 32'd0);
      chk("fl_bd",      {31'd0, dn0.bd},    32'd0);
      chk("fl_pc_keep", dn0.pc, 32'h0000_3010);
      chk("fl_pc_hold", dn1.pc, 32'h0000_3008);
      chk("fl1_instr",  dn1.instr, 32'h0);
`ifdef PIPE_STAGE_PERF_EN
      chk("fl_fcnt", flush_cnt0, 32'd1);
`endif

      // flush during stall is dropped
      stall = 1'b1;
      up_if.pc = 32'h0000_3020;
      tick();
      chk("flstl_pc", dn0.pc, 32'h0000_3010);
`ifdef PIPE_STAGE_PERF_EN
      chk("flstl_fcnt", flush_cnt0, 32'd1);
      chk("flstl_scnt", stall_cnt0, 32'd4);
`endif
      stall = 1'b0; flush = 1'b0;

      // exception merge
      drive(1'b1, 32'h0000_0040, 32'h0000_3024, 1'b0, 5'd4, 5'd10, 32'h0);
      tick();
      chk("exc_old", {27'd0, dn0.exc}, 32'd4);
      drive(1'b1, 32'h0000_0044, 32'h0000_3028, 1'b0, 5'd0, 5'd10, 32'h0);
      tick();
      chk("exc_loc", {27'd0, dn0.exc}, 32'd10);
      drive(1'b0, 32'hFFFF_FFFF, 32'h0000_3030, 1'b1, 5'd4, 5'd10, 32'h0000_0055);
      tick();
      chk("bub_exc",   {27'd0, dn0.exc}, 32'd0);
      chk("bub_instr", dn0.instr, 32'h0);
      chk("bub_imm16", {16'd0, imm16_0}, 32'h0);
      chk("bub_valid", {31'd0, dn0.valid}, 32'd0);
      chk("bub_pc",    dn0.pc,   32'h0000_3030);
      chk("bub_bd",    {31'd0, dn0.bd}, 32'd1);
      chk("bub_data",  dn0.data, 32'h0000_0055);

      // reset released during stall: state stays at reset values
      stall = 1'b1;
      #2 reset = 1'b0;
      #2 reset = 1'b1;
      tick();
      chk("rstl_pc",    dn0.pc, 32'h0000_3000);
      chk("rstl_valid", {31'd0, dn0.valid}, 32'd0);
      chk("rstl_bd",    {31'd0, dn0.bd},    32'd0);
`ifdef PIPE_STAGE_PERF_EN
      chk("rstl_scnt", stall_cnt0, 32'd1);
      chk("rstl_fcnt", flush_cnt0, 32'd0);
`endif
      stall = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
